// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: fixed-latency load/store on a word array,
// stalling the pipeline while busy and flagging illegal or misaligned accesses.
module dmem_responder #(
  parameter int OPERAND_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ctrl_mem_read,
  input  logic                     i_ctrl_mem_write,
  input  logic [OPERAND_WIDTH-1:0] i_addr,
  input  logic [OPERAND_WIDTH-1:0] i_wdata,
  input  logic [2:0]               i_funct3,
  output logic [OPERAND_WIDTH-1:0] o_rdata,
  output logic                     o_rdata_valid,
  output logic                     o_fault,
  output logic                     o_stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]            cnt;
  logic [AW+1:0]            addr_q;
  logic [OPERAND_WIDTH-1:0] wdata_q;
  logic [2:0]               f3_q;
  logic                     wr_q;

  logic [OPERAND_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                     req;
  logic                     accept;
  logic [AW+1:0]            a_e;
  logic [2:0]               f3_e;
  logic                     wr_e;
  logic                     illegal;
  logic                     misal;
  logic                     bad;
  logic [OPERAND_WIDTH-1:0] word;
  logic [OPERAND_WIDTH-1:0] sh_b;
  logic [OPERAND_WIDTH-1:0] sh_h;
  logic [OPERAND_WIDTH-1:0] ld_val;
  logic                     sx;
  logic [3:0]               be;
  logic [OPERAND_WIDTH-1:0] wd_rep;

  assign req    = i_ctrl_mem_read | i_ctrl_mem_write;
  assign accept = (state == IDLE) & req;

  // Outputs are registered on entry to DONE; with one wait state that
  // entry edge is the acceptance edge, so decode from the live inputs.
  always_comb begin
    a_e  = addr_q;
    f3_e = f3_q;
    wr_e = wr_q;
    if (state == IDLE) begin
      a_e  = i_addr[AW+1:0];
      f3_e = i_funct3;
      wr_e = i_ctrl_mem_write;
    end
  end

  always_comb begin
    if (wr_e) illegal = f3_e[2] | (f3_e[1:0] == 2'b11);
    else      illegal = (f3_e[1:0] == 2'b11) | (f3_e[2] & f3_e[1]);
    misal = ((f3_e[1:0] == 2'b01) & a_e[0]) |
            ((f3_e[1:0] == 2'b10) & (|a_e[1:0]));
    bad   = illegal | misal;
  end

  always_comb begin
    word   = mem[a_e[AW+1:2]];
    sh_b   = word >> {a_e[1:0], 3'b000};
    sh_h   = word >> {a_e[1], 4'b0000};
    sx     = ~f3_e[2];
    ld_val = word;
    unique case (1'b1)
      f3_e[1:0] == 2'b00: ld_val = {{24{sx & sh_b[7]}}, sh_b[7:0]};
      f3_e[1:0] == 2'b01: ld_val = {{16{sx & sh_h[15]}}, sh_h[15:0]};
      default:            ld_val = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (WAIT_STATES == 1) ? DONE : WAIT;
      WAIT: if (cnt == CW'(1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_stall = rst & (accept | (state == WAIT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CW'(WAIT_STATES - 1);
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= i_addr[AW+1:0];
      wdata_q <= i_wdata;
      f3_q    <= i_funct3;
      wr_q    <= i_ctrl_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      o_rdata_valid <= (state_nx == DONE) & ~wr_e & ~bad;
      o_fault       <= (state_nx == DONE) & bad;
      if (state_nx == DONE) begin
        if (bad)        o_rdata <= '0;
        else if (!wr_e) o_rdata <= ld_val;
      end
    end
  end

  always_comb begin
    be     = 4'b1111;
    wd_rep = wdata_q;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wd_rep = {4{wdata_q[7:0]}};
      end
      f3_q[1:0] == 2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wdata_q;
      end
    endcase
  end

  // A store lands at the edge leaving DONE; a reset in flight drops it.
  always_ff @(posedge clk) begin
    if (rst && state == DONE && wr_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vectors, multi-cycle corners and
// randomized accesses against a byte-addressed reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rd1, wr1, valid1, fault1, stall1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [2:0]  f31;
  logic        rst3, rd3, wr3, valid3, fault3, stall3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [2:0]  f33;

  dmem_responder #(.OPERAND_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst1),
    .i_ctrl_mem_read(rd1), .i_ctrl_mem_write(wr1),
    .i_addr(addr1), .i_wdata(wdata1), .i_funct3(f31),
    .o_rdata(rdata1), .o_rdata_valid(valid1),
    .o_fault(fault1), .o_stall(stall1)
  );

  dmem_responder #(.OPERAND_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3),
    .i_ctrl_mem_read(rd3), .i_ctrl_mem_write(wr3),
    .i_addr(addr3), .i_wdata(wdata3), .i_funct3(f33),
    .o_rdata(rdata3), .o_rdata_valid(valid3),
    .o_fault(fault3), .o_stall(stall3)
  );

  int pass_cnt = 0;
  int total    = 0;

  logic [7:0] mb [4096];

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        ev;
    logic        ef;
    logic [31:0] er;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    if (sel == 1) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd; f31 = f3;
    end else begin
      rd3 = rd; wr3 = wr; addr3 = a; wdata3 = wd; f33 = f3;
    end
  endtask

  task automatic get(input int sel, output logic s, output logic v,
                     output logic f, output logic [31:0] r);
    if (sel == 1) begin
      s = stall1; v = valid1; f = fault1; r = rdata1;
    end else begin
      s = stall3; v = valid3; f = fault3; r = rdata3;
    end
  endtask

  // One access starting in the cycle after the previous DONE.
  task automatic access(input int sel, input int ws, input string nm,
                        input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic ev,
                        input logic ef, input logic [31:0] er);
    int stalls = 0;
    int n = 0;
    logic early = 1'b0;
    logic s, v, f;
    logic [31:0] r;
    @(negedge clk);
    #1;
    get(sel, s, v, f, r);
    check({nm, " idle pulses"}, {30'd0, v, f}, 32'd0);
    drive(sel, rd, wr, a, wd, f3);
    #1;
    get(sel, s, v, f, r);
    while (s && n < 20) begin
      stalls++;
      if (v | f) early = 1'b1;
      @(negedge clk);
      #1;
      get(sel, s, v, f, r);
      n++;
    end
    check({nm, " done reached"}, 32'(n < 20), 32'd1);
    check({nm, " stall cycles"}, 32'(stalls), 32'(ws));
    check({nm, " early pulse"}, {31'd0, early}, 32'd0);
    check({nm, " rdata_valid"}, {31'd0, v}, {31'd0, ev});
    check({nm, " fault"}, {31'd0, f}, {31'd0, ef});
    if (ev || ef) check({nm, " rdata"}, r, er);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_fault(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
    logic legal;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % nbytes(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [31:0] a);
    int unsigned b = a % 4096;
    int nb = nbytes(f3);
    logic [31:0] v = 0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[b+i]) << (8 * i));
    if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    int unsigned b = a % 4096;
    for (int i = 0; i < nbytes(f3); i++) mb[b+i] = wd[8*i +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s, v, f;
    logic [31:0] r;
    logic seen;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'd2, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,   32'h80,       3'd0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h13,   32'h0,        3'd0, 1'b1, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b1, 1'b0, 32'h13,   32'h0,        3'd4, 1'b1, 1'b0, 32'h00000080};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'd2, 1'b1, 1'b0, 32'h80ADBEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h11,   32'h0,        3'd1, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h12,   32'h11111111, 3'd2, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'd2, 1'b1, 1'b0, 32'h80ADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'd3, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h1000, 32'h12345678, 3'd2, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,    32'h0,        3'd2, 1'b1, 1'b0, 32'h12345678};
    vecs[12] = '{1'b1, 1'b1, 32'h20,   32'hCAFEF00D, 3'd2, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h20,   32'h0,        3'd2, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[14] = '{1'b1, 1'b0, 32'h22,   32'h0,        3'd1, 1'b1, 1'b0, 32'hFFFFCAFE};
    vecs[15] = '{1'b1, 1'b0, 32'h22,   32'h0,        3'd5, 1'b1, 1'b0, 32'h0000CAFE};
    vecs[16] = '{1'b0, 1'b1, 32'h20,   32'h0000BEEF, 3'd1, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 32'h20,   32'h0,        3'd2, 1'b1, 1'b0, 32'hCAFEBEEF};
    vecs[18] = '{1'b1, 1'b0, 32'h21,   32'h0,        3'd0, 1'b1, 1'b0, 32'hFFFFFFBE};

    rst1 = 1'b0;
    rst3 = 1'b0;
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

    // Reset held with a request pending.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      get(1, s, v, f, r);
      check($sformatf("reset%0d stall", c), {31'd0, s}, 32'd0);
      check($sformatf("reset%0d rdata", c), r, 32'd0);
      check($sformatf("reset%0d valid", c), {31'd0, v}, 32'd0);
      check($sformatf("reset%0d fault", c), {31'd0, f}, 32'd0);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    rst1 = 1'b1;
    rst3 = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset idle stall", {31'd0, stall1}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      access(1, 1, $sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr,
             vecs[i].addr, vecs[i].wdata, vecs[i].f3,
             vecs[i].ev, vecs[i].ef, vecs[i].er);
    end

    // Three wait states, then a reset landing on an in-flight store.
    access(3, 3, "ws3 sw", 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 3'd2,
           1'b0, 1'b0, 32'h0);
    access(3, 3, "ws3 lw", 1'b1, 1'b0, 32'h40, 32'h0, 3'd2,
           1'b1, 1'b0, 32'hA5A5A5A5);
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 32'h40, 32'h5A5A5A5A, 3'd2);
    #1;
    check("ws3 rst accept stall", {31'd0, stall3}, 32'd1);
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    #1;
    check("ws3 rst stall", {31'd0, stall3}, 32'd0);
    check("ws3 rst pulses", {30'd0, valid3, fault3}, 32'd0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst3 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (valid3 | fault3 | stall3) seen = 1'b1;
    end
    check("ws3 quiet after reset", {31'd0, seen}, 32'd0);
    access(3, 3, "ws3 lw after rst", 1'b1, 1'b0, 32'h40, 32'h0, 3'd2,
           1'b1, 1'b0, 32'hA5A5A5A5);

    // Randomized traffic over 16 words with random upper address bits.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] a, wd;
      a  = ($urandom << 12) | 32'(w * 4);
      wd = $urandom;
      access(1, 1, $sformatf("init%0d", w), 1'b0, 1'b1, a, wd, 3'd2,
             1'b0, 1'b0, 32'h0);
      model_store(3'd2, a, wd);
    end
    for (int k = 0; k < 300; k++) begin
      logic rd, wr, flt, ev;
      logic [2:0] f3;
      logic [31:0] a, wd, er;
      rd = 1'($urandom);
      wr = 1'($urandom);
      f3 = 3'($urandom);
      a  = ($urandom << 12) | 32'($urandom_range(0, 63));
      wd = $urandom;
      if (!rd && !wr) begin
        @(negedge clk);
        #1;
        check($sformatf("rnd%0d idle", k),
              {29'd0, stall1, valid1, fault1}, 32'd0);
      end else begin
        flt = model_fault(wr, f3, a);
        ev  = !wr && !flt;
        er  = (ev) ? model_load(f3, a) : 32'd0;
        access(1, 1, $sformatf("rnd%0d", k), rd, wr, a, wd, f3,
               ev, flt, er);
        if (wr && !flt) model_store(f3, a, wd);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
